// File: rtl/flex_timer_if.sv
// Control/status bundle for flex_timer. The prescale_val field is present only
// when FLEX_TIMER_PRESCALE_EN is defined.
interface flex_timer_if #(
   parameter int NUM_CNT_BITS  = 8,
   parameter int PRESCALE_BITS = 4
);
   // Control strobes are level-sampled on every rising clk edge; there is no
   // valid/ready pairing: each asserted strobe acts in the cycle it is seen,
   // resolved by priority clear > load > start > tick.
   logic                    clear;
   logic                    start;
   logic                    count_enable;
   logic                    count_up;
   logic                    oneshot;
   logic                    load;
   logic [NUM_CNT_BITS-1:0] load_val;
   logic [NUM_CNT_BITS-1:0] rollover_val;
`ifdef FLEX_TIMER_PRESCALE_EN
   logic [PRESCALE_BITS-1:0] prescale_val;
`endif
   logic [NUM_CNT_BITS-1:0] count_out;
   logic                    rollover_flag;
   logic                    busy;
   logic [1:0]              state_dbg;

   modport master (
      output clear, start, count_enable, count_up, oneshot, load, load_val, rollover_val,
`ifdef FLEX_TIMER_PRESCALE_EN
      output prescale_val,
`endif
      input  count_out, rollover_flag, busy, state_dbg
   );

   modport slave (
      input  clear, start, count_enable, count_up, oneshot, load, load_val, rollover_val,
`ifdef FLEX_TIMER_PRESCALE_EN
      input  prescale_val,
`endif
      output count_out, rollover_flag, busy, state_dbg
   );
endinterface

// File: rtl/flex_timer.sv
// Up/down counter/timer with wrap or one-shot mode, sync load and IDLE/RUN/DONE FSM.
// Optional tick prescaler enabled by defining FLEX_TIMER_PRESCALE_EN.
module flex_timer #(
   parameter int NUM_CNT_BITS  = 8,
   parameter int PRESCALE_BITS = 4
) (
   input logic         clk,
   input logic         n_rst,
   flex_timer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

   state_t                  state_q, state_d;
   logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
   logic                    flag_q, flag_d;
   logic                    busy_q, busy_d;
   logic                    tick;
   logic [NUM_CNT_BITS-1:0] term_val;
   logic [NUM_CNT_BITS-1:0] tick_val;
   logic                    run_en;

   assign run_en   = (state_q == RUN) && bus.count_enable;
   assign term_val = bus.count_up ? bus.rollover_val : CNT_ZERO;

`ifdef FLEX_TIMER_PRESCALE_EN
   logic [PRESCALE_BITS-1:0] presc_q, presc_d;
   localparam logic [PRESCALE_BITS-1:0] PRESC_ONE = PRESCALE_BITS'(1);

   // Prescaler is zeroed by any control strobe so a restart begins a full period.
   always_comb begin
      presc_d = presc_q;
      tick    = 1'b0;
      if (bus.clear || bus.load || bus.start) begin
         presc_d = '0;
      end else if (run_en) begin
         if (presc_q == bus.prescale_val) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PRESC_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) presc_q <= '0;
      else        presc_q <= presc_d;
   end
`else
   assign tick = run_en;
`endif

   // Out-of-range counts snap back into the [0..R] window instead of overflowing.
   always_comb begin
      tick_val = cnt_q;
      if (bus.count_up) begin
         if (cnt_q >= bus.rollover_val)
            tick_val = (bus.rollover_val == CNT_ZERO) ? CNT_ZERO : CNT_ONE;
         else
            tick_val = cnt_q + CNT_ONE;
      end else begin
         if ((cnt_q == CNT_ZERO) || (cnt_q > bus.rollover_val))
            tick_val = bus.rollover_val;
         else
            tick_val = cnt_q - CNT_ONE;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.clear) begin
         state_d = IDLE;
         cnt_d   = CNT_ZERO;
      end else if (bus.load) begin
         cnt_d = bus.load_val;
      end else if (bus.start) begin
         state_d = RUN;
         if (state_q == DONE)
            cnt_d = bus.count_up ? CNT_ZERO : bus.rollover_val;
      end else if (tick) begin
         cnt_d = tick_val;
         if (bus.oneshot && (tick_val == term_val))
            state_d = DONE;
      end
      // Status is derived from next-state values so it lines up with count_out.
      flag_d = (state_d != IDLE) && (cnt_d == term_val);
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
         flag_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.count_out     = cnt_q;
   assign bus.rollover_flag = flag_q;
   assign bus.busy          = busy_q;
   assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_flex_timer.sv
// Directed plus randomised checks of flex_timer with an expected-value queue.
module tb_flex_timer;
  logic clk;
  logic n_rst;
  int   tests_run;
  int   fail_cnt;
  logic [9:0] exp_q[$];

  flex_timer_if #(.NUM_CNT_BITS(8), .PRESCALE_BITS(4)) bus ();

  flex_timer #(.NUM_CNT_BITS(8), .PRESCALE_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] act, input logic [9:0] exp);
    tests_run++;
    assert (act === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got cnt=%0d flag=%0b busy=%0b, exp cnt=%0d flag=%0b busy=%0b",
             tag, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    tests_run++;
    assert (bus.state_dbg === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got state=%0d exp state=%0d", tag, bus.state_dbg, exp);
    end
  endtask

  // Push expectation, clock once, then compare what the DUT shows after the edge.
  task automatic step(input string tag, input logic [7:0] c, input logic f, input logic b);
    logic [9:0] e;
    exp_q.push_back({c, f, b});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, {bus.count_out, bus.rollover_flag, bus.busy}, e);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step("clear", 8'd0, 1'b0, 1'b0);
    bus.clear = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] r;
    logic       up;
    int         ticks;
    logic [7:0] v;
    tests_run = 0;
    fail_cnt  = 0;
    n_rst = 1'b1;
    bus.clear = 1'b0; bus.start = 1'b0; bus.count_enable = 1'b0;
    bus.count_up = 1'b1; bus.oneshot = 1'b0; bus.load = 1'b0;
    bus.load_val = 8'd0; bus.rollover_val = 8'd0;
`ifdef FLEX_TIMER_PRESCALE_EN
    bus.prescale_val = 4'd0;
`endif
    #3 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.count_out, bus.rollover_flag, bus.busy}, 10'd0);
    chk_state("reset_fsm", 2'd0);
    @(negedge clk) n_rst = 1'b1;

    // Async reset in the middle of a run at count 5
    bus.rollover_val = 8'd10; bus.count_up = 1'b1;
    bus.start = 1'b1;
    step("t1_start", 8'd0, 1'b0, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    for (int i = 1; i <= 5; i++) step("t1_count", 8'(i), 1'b0, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("t1_async_reset", {bus.count_out, bus.rollover_flag, bus.busy}, 10'd0);
    bus.count_enable = 1'b0;
    @(negedge clk) n_rst = 1'b1;

    // R=4 up continuous
    bus.rollover_val = 8'd4; bus.count_up = 1'b1; bus.oneshot = 1'b0;
    bus.start = 1'b1;
    step("t2_start", 8'd0, 1'b0, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    step("t2_c1", 8'd1, 1'b0, 1'b1);
    step("t2_c2", 8'd2, 1'b0, 1'b1);
    step("t2_c3", 8'd3, 1'b0, 1'b1);
    step("t2_c4", 8'd4, 1'b1, 1'b1);
    step("t2_c1b", 8'd1, 1'b0, 1'b1);
    step("t2_c2b", 8'd2, 1'b0, 1'b1);
    bus.count_enable = 1'b0;
    do_clear();

    // R=3 down oneshot
    bus.rollover_val = 8'd3; bus.count_up = 1'b0; bus.oneshot = 1'b1;
    bus.load = 1'b1; bus.load_val = 8'd3;
    step("t3_load_idle", 8'd3, 1'b0, 1'b0);
    bus.load = 1'b0; bus.start = 1'b1;
    step("t3_start", 8'd3, 1'b0, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    step("t3_c2", 8'd2, 1'b0, 1'b1);
    step("t3_c1", 8'd1, 1'b0, 1'b1);
    step("t3_c0_done", 8'd0, 1'b1, 1'b0);
    chk_state("t3_fsm_done", 2'd2);
    step("t3_hold1", 8'd0, 1'b1, 1'b0);
    step("t3_hold2", 8'd0, 1'b1, 1'b0);
    bus.start = 1'b1;
    step("t3_restart", 8'd3, 1'b0, 1'b1);
    chk_state("t3_fsm_run", 2'd1);
    bus.start = 1'b0;
    step("t3_after_restart", 8'd2, 1'b0, 1'b1);
    bus.oneshot = 1'b0;
    do_clear();

    // Priority: clear > load > start > tick
    bus.rollover_val = 8'd5; bus.count_up = 1'b1; bus.count_enable = 1'b1;
    bus.clear = 1'b1; bus.load = 1'b1; bus.start = 1'b1; bus.load_val = 8'd7;
    step("t4_clear_wins", 8'd0, 1'b0, 1'b0);
    chk_state("t4_fsm_idle", 2'd0);
    bus.clear = 1'b0; bus.load = 1'b0;
    step("t4_start_over_tick", 8'd0, 1'b0, 1'b1);
    bus.start = 1'b0; bus.load = 1'b1; bus.load_val = 8'd3;
    step("t4_load_over_tick", 8'd3, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("t4_c4", 8'd4, 1'b0, 1'b1);
    step("t4_c5", 8'd5, 1'b1, 1'b1);
    step("t4_c1", 8'd1, 1'b0, 1'b1);
    bus.load = 1'b1; bus.load_val = 8'd5;
    step("t4_load_term", 8'd5, 1'b1, 1'b1);
    bus.load = 1'b0;
    step("t4_after_load", 8'd1, 1'b0, 1'b1);
    bus.count_enable = 1'b0;
    do_clear();

    // Edge: R=0 up stays at 0 with flag high
    bus.rollover_val = 8'd0; bus.count_up = 1'b1;
    bus.start = 1'b1;
    step("t5_r0_start", 8'd0, 1'b1, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    for (int i = 0; i < 3; i++) step("t5_r0_tick", 8'd0, 1'b1, 1'b1);
    bus.count_enable = 1'b0;
    do_clear();

    // Edge: R=255 up wraps to 1
    bus.rollover_val = 8'd255;
    bus.load = 1'b1; bus.load_val = 8'd254;
    step("t5_load254", 8'd254, 1'b0, 1'b0);
    bus.load = 1'b0; bus.start = 1'b1;
    step("t5_start254", 8'd254, 1'b0, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    step("t5_c255", 8'd255, 1'b1, 1'b1);
    step("t5_wrap1", 8'd1, 1'b0, 1'b1);
    step("t5_c2", 8'd2, 1'b0, 1'b1);
    bus.count_enable = 1'b0;
    do_clear();

    // Down continuous from 0, and out-of-range reload
    bus.rollover_val = 8'd2; bus.count_up = 1'b0;
    bus.start = 1'b1;
    step("dn_start", 8'd0, 1'b1, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    step("dn_r", 8'd2, 1'b0, 1'b1);
    step("dn_1", 8'd1, 1'b0, 1'b1);
    step("dn_0", 8'd0, 1'b1, 1'b1);
    step("dn_r2", 8'd2, 1'b0, 1'b1);
    bus.count_enable = 1'b0; bus.load = 1'b1; bus.load_val = 8'd9;
    step("dn_load9", 8'd9, 1'b0, 1'b1);
    bus.load = 1'b0; bus.count_enable = 1'b1;
    step("dn_snap_r", 8'd2, 1'b0, 1'b1);
    bus.count_enable = 1'b0;
    do_clear();

    // Tick rate: every 3rd clock with prescaler=2, every clock otherwise
    bus.rollover_val = 8'd2; bus.count_up = 1'b1;
`ifdef FLEX_TIMER_PRESCALE_EN
    bus.prescale_val = 4'd2;
`endif
    bus.start = 1'b1;
    step("t6_start", 8'd0, 1'b0, 1'b1);
    bus.start = 1'b0; bus.count_enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
`ifdef FLEX_TIMER_PRESCALE_EN
      ticks = i / 3;
`else
      ticks = i;
`endif
      v = (ticks == 0) ? 8'd0 : 8'(((ticks - 1) % 2) + 1);
      step("t6_rate", v, (v == 8'd2), 1'b1);
    end
    bus.count_enable = 1'b0;
`ifdef FLEX_TIMER_PRESCALE_EN
    bus.prescale_val = 4'd0;
`endif
    do_clear();

    // Random R, both directions, continuous mode against a reference model
    for (int t = 0; t < 4; t++) begin
      r  = 8'($urandom_range(1, 30));
      up = t[0];
      bus.rollover_val = r; bus.count_up = up; bus.oneshot = 1'b0;
      bus.start = 1'b1;
      m = 8'd0;
      step("rnd_start", m, (m == (up ? r : 8'd0)), 1'b1);
      bus.start = 1'b0; bus.count_enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
        if (up) m = (m >= r) ? 8'd1 : m + 8'd1;
        else    m = (m == 8'd0 || m > r) ? r : m - 8'd1;
        step("rnd_tick", m, (m == (up ? r : 8'd0)), 1'b1);
      end
      bus.count_enable = 1'b0;
      do_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
